// File: rtl/alu_decode_stage.sv
// RV32I integer decode stage: turns OP / OP-IMM / LUI / AUIPC into ALU operands and op code
// behind a valid/ready output register. Define ALU_DECODE_SKID_EN to add a one-entry skid buffer.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } entry_t;

    // Op code for the funct3 values that need no funct7 qualification.
    function automatic logic [3:0] f3_to_ctrl(input logic [2:0] f3);
        logic [3:0] c;
        case (f3)
            3'b000:  c = ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_ctrl;
    logic        dec_ok;
    entry_t      dec;

    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        dec_ctrl = ALU_ADD;
        dec_ok   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                if (funct7 == F7_ZERO) begin
                    dec_ok   = 1'b1;
                    dec_ctrl = f3_to_ctrl(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        dec_ok   = 1'b1;
                        dec_ctrl = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_ok   = 1'b1;
                        dec_ctrl = ALU_SRA;
                    end
                end
            end
            OPC_IMM: begin
                dec_a = rs1_data;
                dec_b = imm_i;
                case (funct3)
                    3'b001: begin
                        dec_ok   = (funct7 == F7_ZERO);
                        dec_ctrl = ALU_SLL;
                    end
                    3'b101: begin
                        dec_ok   = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: begin
                        dec_ok   = 1'b1;
                        dec_ctrl = f3_to_ctrl(funct3);
                    end
                endcase
            end
            OPC_LUI: begin
                dec_ok = 1'b1;
                dec_b  = imm_u;
            end
            OPC_AUIPC: begin
                dec_ok = 1'b1;
                dec_a  = pc;
                dec_b  = imm_u;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Illegal encodings still flow downstream, but as an inert ADD 0,0 with no writeback.
    always_comb begin
        dec.a    = dec_ok ? dec_a : 32'd0;
        dec.b    = dec_ok ? dec_b : 32'd0;
        dec.ctrl = dec_ok ? dec_ctrl : ALU_ADD;
        dec.rd   = instr[11:7];
        dec.rw   = dec_ok && (instr[11:7] != 5'd0);
        dec.ill  = !dec_ok;
    end

    entry_t out_q;
    entry_t out_d;
    logic   out_valid_q;
    logic   out_valid_d;
    logic   in_fire;

`ifdef ALU_DECODE_SKID_EN
    entry_t skid_q;
    entry_t skid_d;
    logic   skid_valid_q;
    logic   skid_valid_d;
    logic   in_ready_q;

    assign in_ready = in_ready_q;
    assign in_fire  = in_valid && in_ready_q;

    // The output register prefers the skid entry so ordering is preserved.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = in_fire;
                if (in_fire) begin
                    skid_d = dec;
                end
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = dec;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (in_ready) begin
            out_valid_d = in_valid;
            if (in_valid) begin
                out_d = dec;
            end
        end
    end
`endif

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_fire && dec.ill && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_a       = out_q.a;
    assign alu_b       = out_q.b;
    assign alu_ctrl    = out_q.ctrl;
    assign rd          = out_q.rd;
    assign reg_write   = out_q.rw;
    assign illegal     = out_q.ill;
    assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: queue-based reference model checked every cycle, plus literal vectors.
// Honours ALU_DECODE_SKID_EN for the in_ready and stall-acceptance expectations.
module tb_alu_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    alu_decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .rd(rd), .reg_write(reg_write), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    // ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND indexed by funct3
    int optab[8] = '{0, 6, 5, 9, 4, 8, 3, 2};

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] a;
        logic [31:0] b;
        f3 = ins[14:12];
        f7 = ins[31:25];
        op = -1;
        a  = 0;
        b  = 0;
        if (ins[6:0] == 7'h33) begin
            a = r1; b = r2;
            if (f7 == 0) op = optab[f3];
            else if (f7 == 7'h20 && f3 == 0) op = 1;
            else if (f7 == 7'h20 && f3 == 5) op = 7;
        end else if (ins[6:0] == 7'h13) begin
            a = r1; b = 32'($signed(ins[31:20]));
            if (f3 == 1) op = (f7 == 0) ? 6 : -1;
            else if (f3 == 5) op = (f7 == 0) ? 8 : (f7 == 7'h20) ? 7 : -1;
            else op = optab[f3];
        end else if (ins[6:0] == 7'h37) begin
            a = 0; b = ins & 32'hFFFFF000; op = 0;
        end else if (ins[6:0] == 7'h17) begin
            a = p; b = ins & 32'hFFFFF000; op = 0;
        end
        e.rd = ins[11:7];
        if (op < 0) begin
            e.a = 0; e.b = 0; e.ctrl = 0; e.rw = 0; e.ill = 1;
        end else begin
            e.a = a; e.b = b; e.ctrl = 4'(op); e.rw = (ins[11:7] != 0); e.ill = 0;
        end
        return e;
    endfunction

    exp_t q[$];
    int   cnt_m = 0;

    always @(negedge rst) begin
        q.delete();
        cnt_m = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(instr, pc, rs1_data, rs2_data);
                q.push_back(e);
                if (e.ill && cnt_m < 255) cnt_m++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
            chk("rst_rd", 32'(rd), 0);
            chk("rst_reg_write", 32'(reg_write), 0);
            chk("rst_illegal", 32'(illegal), 0);
            chk("rst_illegal_cnt", 32'(illegal_cnt), 0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("alu_a", alu_a, q[0].a);
                chk("alu_b", alu_b, q[0].b);
                chk("alu_ctrl", 32'(alu_ctrl), 32'(q[0].ctrl));
                chk("rd", 32'(rd), 32'(q[0].rd));
                chk("reg_write", 32'(reg_write), 32'(q[0].rw));
                chk("illegal", 32'(illegal), 32'(q[0].ill));
            end
            chk("illegal_cnt", 32'(illegal_cnt), 32'(cnt_m));
`ifdef ALU_DECODE_SKID_EN
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
`else
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
`endif
        end
    end

    logic [7:0] pat = 8'b1011_0110;
    int         pat_i = 0;

    // Present one instruction until accepted; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input bit toggle);
        bit ok;
        ok = 0;
        in_valid = 1; instr = i; pc = p; rs1_data = a; rs2_data = b;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            if (in_ready) ok = 1;
            #1;
            if (toggle) begin
                out_ready = pat[pat_i % 8];
                pat_i++;
            end
            if (ok) break;
        end
        in_valid = 0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr %h not accepted within 50 cycles", i);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] vec[24] = '{
        32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3,
        32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h4020F1B3, 32'h00A32293,
        32'hFF837293, 32'h00331293, 32'h40331293, 32'h00335293, 32'h20335293, 32'h80030293,
        32'hABCDE3B7, 32'h0000007F, 32'h00002003, 32'h00000013, 32'h12345017, 32'h4020C1B3
    };
    logic [31:0] stall_vec[4] = '{32'h00130113, 32'h00230193, 32'h00330213, 32'h00430293};

    initial begin
        int acc;
        int idx;
        tick(3);
        rst = 1;
        tick(1);
        chk("in_ready_after_rst", 32'(in_ready), 1);

        send(32'h40208033, 0, 5, 3, 0);
        chk("lit_sub_valid", 32'(out_valid), 1);
        chk("lit_sub_ctrl", 32'(alu_ctrl), 1);
        chk("lit_sub_a", alu_a, 5);
        chk("lit_sub_b", alu_b, 3);
        chk("lit_sub_rd", 32'(rd), 0);
        chk("lit_sub_rw", 32'(reg_write), 0);

        send(32'hFFF10093, 0, 7, 0, 0);
        chk("lit_addi_ctrl", 32'(alu_ctrl), 0);
        chk("lit_addi_b", alu_b, 32'hFFFFFFFF);
        chk("lit_addi_rd", 32'(rd), 1);
        chk("lit_addi_rw", 32'(reg_write), 1);

        send(32'h4050D093, 0, 9, 0, 0);
        chk("lit_srai_ctrl", 32'(alu_ctrl), 7);
        chk("lit_srai_b", alu_b, 32'h00000405);

        send(32'h02208033, 0, 1, 2, 0);
        chk("lit_ill_illegal", 32'(illegal), 1);
        chk("lit_ill_rw", 32'(reg_write), 0);
        chk("lit_ill_cnt", 32'(illegal_cnt), 1);

        send(32'h12345097, 32'h100, 0, 0, 0);
        chk("lit_auipc_a", alu_a, 32'h100);
        chk("lit_auipc_b", alu_b, 32'h12345000);
        chk("lit_auipc_ctrl", 32'(alu_ctrl), 0);

        for (int k = 0; k < 24; k++)
            send(vec[k], 32'h1000 + 32'(k * 4), 32'h8000_0000 + 32'(k), 32'(k * 3 + 1), 1);
        out_ready = 1;
        tick(4);
        chk("table_drained", 32'(q.size()), 0);

        // Output stalled with a steady stream offered.
        tick(1);
        out_ready = 0;
        acc = 0;
        in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            instr = stall_vec[acc]; pc = 0; rs1_data = 32'(100 + acc); rs2_data = 0;
            @(posedge clk);
            if (in_ready) acc++;
            #1;
        end
        in_valid = 0;
`ifdef ALU_DECODE_SKID_EN
        chk("stall_accepted", 32'(acc), 2);
`else
        chk("stall_accepted", 32'(acc), 1);
`endif
        out_ready = 1;
        for (idx = acc; idx < 4; idx++) send(stall_vec[idx], 0, 32'(100 + idx), 0, 0);
        tick(4);
        chk("stall_drained", 32'(out_valid), 0);
        chk("stall_model_empty", 32'(q.size()), 0);

        for (int k = 0; k < 300; k++) send(32'h0000007F, 0, 0, 0, 0);
        tick(1);
        chk("lit_cnt_saturated", 32'(illegal_cnt), 255);

        send(32'h00500093, 0, 0, 0, 0);
        out_ready = 0;
        in_valid = 1; instr = 32'h00600093;
        tick(3);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 0;
        #1;
        chk("lit_rst_out_valid", 32'(out_valid), 0);
        chk("lit_rst_cnt", 32'(illegal_cnt), 0);
        in_valid = 0;
        out_ready = 1;
        tick(2);
        rst = 1;
        tick(1);
        chk("in_ready_after_rst2", 32'(in_ready), 1);
        send(32'hABCDE3B7, 0, 0, 0, 0);
        chk("lit_lui_b", alu_b, 32'hABCDE000);
        chk("lit_lui_a", alu_a, 0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-004 SHALL have ports instr (input, 32), pc (input, 32), rs1_data (input, 32) and rs2_data (input, 32), the upstream payload.
REQ-005 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-006 SHALL have ports alu_a (output, 32), alu_b (output, 32) and alu_ctrl (output, 4), the ALU operands and op code.
REQ-007 SHALL have ports rd (output, 5), reg_write (output, 1) and illegal (output, 1), the writeback tag and the decode-fault flag.
REQ-008 SHALL have port illegal_cnt, output, 8, saturating count of accepted illegal instructions.

Function
REQ-009 SHALL transfer on the input side when in_valid&in_ready and on the output side when out_valid&out_ready; payload SHALL be held stable while out_valid&!out_ready.
REQ-010 SHALL produce alu_ctrl with encoding 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRA, 1000 SRL, 1001 SLTU.
REQ-011 SHALL decode OP (opcode 0110011): A=rs1_data, B=rs2_data, op from funct3 and funct7; funct7 0100000 is legal only for funct3 000 (SUB) and 101 (SRA); any other funct7 except 0000000 SHALL set illegal.
REQ-012 SHALL decode OP-IMM (opcode 0010011): A=rs1_data, B=sign-extended instr[31:20]; funct3 000 SHALL always be ADD; SLLI requires instr[31:25]=0000000; SRLI/SRAI requires 0000000/0100000; any other value SHALL set illegal.
REQ-013 SHALL decode LUI (opcode 0110111) as A=0, B={instr[31:12],12'b0}, ADD.
REQ-014 SHALL decode AUIPC (opcode 0010111) as A=pc, B={instr[31:12],12'b0}, ADD.
REQ-015 SHALL pass rd=instr[11:7]; reg_write=1 iff the instruction is legal and rd!=0.
REQ-016 SHALL, for any other opcode or an illegal encoding, still accept and emit the instruction with illegal=1, reg_write=0, alu_ctrl=0000, A=B=0.
REQ-017 SHALL have latency of exactly 1 cycle from input transfer to out_valid when the output is empty; throughput SHALL be 1 per cycle when out_ready stays high.
REQ-018 SHALL increment illegal_cnt on each input transfer with illegal decode and saturate at 255 (no wrap).
REQ-019 SHALL NOT lose or duplicate an instruction under any in_valid/out_ready pattern; a simultaneous input and output transfer SHALL replace the output entry in that same cycle.

Reset
REQ-020 SHALL, while rst=0, force out_valid=0, alu_a=alu_b=0, alu_ctrl=0, rd=0, reg_write=0, illegal=0 and illegal_cnt=0, and empty any skid entry.
REQ-021 SHALL discard in-flight entries on reset mid-operation; in_ready SHALL be 1 after the first clk edge following rst deassertion.

Configuration
REQ-022 SHALL, with macro ALU_DECODE_SKID_EN defined, add a one-entry skid buffer: in_ready driven only from a flop (=!skid_full); on an input transfer while the output is stalled, the data SHALL go to the skid, which drains into the output on the next output transfer.
REQ-023 SHALL, with ALU_DECODE_SKID_EN undefined, use a single output register and set in_ready = !out_valid | out_ready (combinational path from out_ready).

Verification
REQ-024 SHALL pass: accept instr 0x40208033 (sub x0,x1,x2) with rs1=5, rs2=3 -> next cycle out_valid=1, alu_ctrl=0001, a=5, b=3, rd=0, reg_write=0.
REQ-025 SHALL pass: accept instr 0xFFF10093 (addi x1,x2,-1) with rs1=7 -> alu_ctrl=0000, b=0xFFFFFFFF, rd=1, reg_write=1.
REQ-026 SHALL pass: accept instr 0x4050D093 (srai x1,x1,5) -> alu_ctrl=0111, b=0x00000405; then accept 0x02208033 (funct7 0000001) -> illegal=1, reg_write=0, illegal_cnt=1.
REQ-027 SHALL pass: accept instr 0x12345097 (auipc x1) with pc=0x100 -> a=0x100, b=0x12345000, alu_ctrl=0000.
REQ-028 SHALL pass: hold out_ready=0 for 5 cycles with in_valid=1 and distinct instructions -> output stable; with the skid macro 2 entries are accepted, without it 1; after out_ready=1 they emerge in order with no loss.
REQ-029 SHALL pass: apply 300 illegal instructions -> illegal_cnt=255; then assert rst=0 mid-stall -> out_valid=0 and illegal_cnt=0 immediately.
